// File: rtl/vscale_csr_unit.sv
// ---------------------------------------------------------------------------
// vscale_csr_unit
//
// Machine-level CSR file and privilege stack for the 3-stage vscale core.
// It accepts WB-stage CSR commands, exceptions and retire events from
// vscale_ctrl, plus the kill-qualified eret from DX. It returns the CSR read
// data, an illegal-access flag, the current privilege, mepc and the trap
// handler PC for the current privilege.
//
// Ports
//   clk                 core clock
//   reset               synchronous, active-high reset
//   addr                CSR address (WB stage)
//   cmd                 0 IDLE, 4 READ, 5 WRITE, 6 SET, 7 CLEAR
//   wdata               write operand (rs1 or zimm)
//   retire              WB instruction retires this cycle
//   exception           trap taken in WB this cycle
//   exception_code      cause code of the trap
//   exception_PC        PC of the trapping instruction
//   exception_load_addr faulting data address
//   eret                privilege-stack pop request
//   rdata               combinational read of addr (pre-write value)
//   illegal_access      combinational; cmd != IDLE and the access is illegal
//   prv                 current privilege (mstatus.PRV)
//   epc                 mepc
//   handler_PC          trap vector for the current privilege
// ---------------------------------------------------------------------------
module vscale_csr_unit #(
    parameter int                 XPR_LEN    = 32,
    parameter logic [XPR_LEN-1:0] MTVEC_BASE = 32'h100,
    parameter logic [XPR_LEN-1:0] MCPUID_VAL = 32'h0,
    parameter logic [XPR_LEN-1:0] MIMPID_VAL = 32'h8000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        addr,
    input  logic [2:0]         cmd,
    input  logic [XPR_LEN-1:0] wdata,
    input  logic               retire,
    input  logic               exception,
    input  logic [3:0]         exception_code,
    input  logic [XPR_LEN-1:0] exception_PC,
    input  logic [XPR_LEN-1:0] exception_load_addr,
    input  logic               eret,
    output logic [XPR_LEN-1:0] rdata,
    output logic               illegal_access,
    output logic [1:0]         prv,
    output logic [XPR_LEN-1:0] epc,
    output logic [XPR_LEN-1:0] handler_PC
);

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd5;
    localparam logic [2:0] CMD_SET   = 3'd6;
    localparam logic [2:0] CMD_CLEAR = 3'd7;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MBADADDR = 12'h343;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [11:0] ADDR_MCPUID   = 12'hF00;
    localparam logic [11:0] ADDR_MIMPID   = 12'hF01;

    // Privilege stack (prv itself is the output register)
    logic               ie;
    logic               ie1;
    logic [1:0]         prv1;

    logic [XPR_LEN-1:0] mscratch;
    logic [XPR_LEN-1:0] mepc;
    logic [XPR_LEN-1:0] mcause;
    logic [XPR_LEN-1:0] mbadaddr;
    logic [63:0]        cycle;
    // instret kept as two halves so each word is an independent register
    logic [31:0]        instret_lo;
    logic [31:0]        instret_hi;

    logic               implemented;
    logic               cmd_writes;
    logic [XPR_LEN-1:0] new_val;
    logic               wen;

    logic               st_ie;
    logic               st_ie1;
    logic [1:0]         st_prv;
    logic [1:0]         st_prv1;

    // Read mux; unimplemented addresses read as zero
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (addr)
            ADDR_MSTATUS:  rdata = {{(XPR_LEN-6){1'b0}}, prv1, ie1, prv, ie};
            ADDR_MSCRATCH: rdata = mscratch;
            ADDR_MEPC:     rdata = mepc;
            ADDR_MCAUSE:   rdata = mcause;
            ADDR_MBADADDR: rdata = mbadaddr;
            ADDR_CYCLE:    rdata = cycle[31:0];
            ADDR_CYCLEH:   rdata = cycle[63:32];
            ADDR_INSTRET:  rdata = instret_lo;
            ADDR_INSTRETH: rdata = instret_hi;
            ADDR_MCPUID:   rdata = MCPUID_VAL;
            ADDR_MIMPID:   rdata = MIMPID_VAL;
            default:       implemented = 1'b0;
        endcase
    end

    assign cmd_writes = (cmd == CMD_WRITE) || (cmd == CMD_SET) || (cmd == CMD_CLEAR);

    // addr[9:8] encodes the minimum privilege, addr[11:10]==3 marks read-only
    assign illegal_access = (cmd != CMD_IDLE) &&
                            (!implemented ||
                             (addr[9:8] > prv) ||
                             ((addr[11:10] == 2'b11) && cmd_writes));

    // Read-modify-write operand built from the pre-write value
    always_comb begin
        new_val = wdata;
        case (cmd)
            CMD_SET:   new_val = rdata | wdata;
            CMD_CLEAR: new_val = rdata & ~wdata;
            default:   new_val = wdata;
        endcase
    end

    assign wen = cmd_writes && retire && !exception && !illegal_access;

    // Next privilege stack when no trap is taken: the WB mstatus write is
    // the older instruction, so an eret pop acts on the freshly written value
    always_comb begin
        st_ie   = ie;
        st_prv  = prv;
        st_ie1  = ie1;
        st_prv1 = prv1;
        if (wen && (addr == ADDR_MSTATUS)) begin
            st_ie   = new_val[0];
            st_prv  = new_val[2:1];
            st_ie1  = new_val[3];
            st_prv1 = new_val[5:4];
        end
        if (eret) begin
            st_prv  = st_prv1;
            st_ie   = st_ie1;
            st_prv1 = 2'b00;
            st_ie1  = 1'b1;
        end
    end

    // State update; a trap overrides any same-cycle CSR write and eret
    always_ff @(posedge clk) begin
        if (reset) begin
            prv        <= 2'b11;
            ie         <= 1'b0;
            prv1       <= 2'b11;
            ie1        <= 1'b0;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mbadaddr   <= '0;
            cycle      <= '0;
            instret_lo <= '0;
            instret_hi <= '0;
        end else begin
            cycle <= cycle + 64'd1;
            if (retire && !exception) begin
                {instret_hi, instret_lo} <= {instret_hi, instret_lo} + 64'd1;
            end
            if (exception) begin
                mepc   <= exception_PC & ~{{(XPR_LEN-2){1'b0}}, 2'b11};
                mcause <= {{(XPR_LEN-4){1'b0}}, exception_code};
                if ((exception_code == 4'd4) || (exception_code == 4'd6)) begin
                    mbadaddr <= exception_load_addr;
                end
                prv1 <= prv;
                ie1  <= ie;
                prv  <= 2'b11;
                ie   <= 1'b0;
            end else begin
                prv  <= st_prv;
                ie   <= st_ie;
                prv1 <= st_prv1;
                ie1  <= st_ie1;
                if (wen) begin
                    case (addr)
                        ADDR_MSCRATCH: mscratch <= new_val;
                        ADDR_MEPC:     mepc     <= {new_val[XPR_LEN-1:2], 2'b00};
                        ADDR_MCAUSE:   mcause   <= {new_val[XPR_LEN-1], {(XPR_LEN-5){1'b0}},
                                                    new_val[3:0]};
                        ADDR_MBADADDR: mbadaddr <= new_val;
                        default:       ;
                    endcase
                end
            end
        end
    end

    assign epc        = mepc;
    assign handler_PC = MTVEC_BASE + {{(XPR_LEN-8){1'b0}}, prv, 6'b000000};

endmodule

// File: tb/tb_vscale_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_vscale_csr_unit
//
// Self-checking bench for vscale_csr_unit. A behavioural model of the CSR
// file (plain fields and 64-bit counters) predicts every output; directed
// steps cover reset, read-modify-write, traps, eret and counter wrap, then a
// randomized run exercises the remaining combinations.
// ---------------------------------------------------------------------------
module tb_vscale_csr_unit;

    logic        clk;
    logic        reset;
    logic [11:0] addr;
    logic [2:0]  cmd;
    logic [31:0] wdata;
    logic        retire;
    logic        exception;
    logic [3:0]  exception_code;
    logic [31:0] exception_PC;
    logic [31:0] exception_load_addr;
    logic        eret;
    logic [31:0] rdata;
    logic        illegal_access;
    logic [1:0]  prv;
    logic [31:0] epc;
    logic [31:0] handler_PC;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_ie, m_prv, m_ie1, m_prv1;
    logic [31:0] m_scratch, m_epc, m_cause, m_bad;
    logic [63:0] m_cycle, m_instret;

    vscale_csr_unit dut (
        .clk                (clk),
        .reset              (reset),
        .addr               (addr),
        .cmd                (cmd),
        .wdata              (wdata),
        .retire             (retire),
        .exception          (exception),
        .exception_code     (exception_code),
        .exception_PC       (exception_PC),
        .exception_load_addr(exception_load_addr),
        .eret               (eret),
        .rdata              (rdata),
        .illegal_access     (illegal_access),
        .prv                (prv),
        .epc                (epc),
        .handler_PC         (handler_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_known(input logic [11:0] a);
        case (a)
            12'h300, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF00, 12'hF01: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'(m_prv1 * 16 + m_ie1 * 8 + m_prv * 2 + m_ie);
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_bad;
            12'hC00: return m_cycle[31:0];
            12'hC80: return m_cycle[63:32];
            12'hC02: return m_instret[31:0];
            12'hC82: return m_instret[63:32];
            12'hF00: return 32'h0;
            12'hF01: return 32'h8000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_is_write(input logic [2:0] c);
        return (c == 3'd5) || (c == 3'd6) || (c == 3'd7);
    endfunction

    function automatic bit m_illegal(input logic [11:0] a, input logic [2:0] c);
        if (c == 3'd0) return 1'b0;
        if (!m_known(a)) return 1'b1;
        if (int'(a[9:8]) > m_prv) return 1'b1;
        if (a[11:10] == 2'b11 && m_is_write(c)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [11:0] a, input logic [2:0] c,
                                 input logic [31:0] wd, input logic ret, input logic exc,
                                 input logic [3:0] code, input logic [31:0] pc,
                                 input logic [31:0] la, input logic er);
        reset = rst; addr = a; cmd = c; wdata = wd; retire = ret; exception = exc;
        exception_code = code; exception_PC = pc; exception_load_addr = la; eret = er;
    endtask

    // Compare every output with the model, away from the active edge
    task automatic checkOutput(input string tag);
        @(negedge clk);
        if (!reset) begin
            check({tag, "_rdata"}, rdata, m_read(addr));
            check({tag, "_illegal"}, {31'b0, illegal_access}, {31'b0, m_illegal(addr, cmd)});
        end
        check({tag, "_prv"}, {30'b0, prv}, 32'(m_prv));
        check({tag, "_epc"}, epc, m_epc);
        check({tag, "_handler"}, handler_PC, 32'h100 + 32'(m_prv * 64));
    endtask

    // Advance one clock edge and apply the architectural rules to the model
    task automatic tick();
        logic [31:0] oldv, newv;
        bit          ill;
        @(posedge clk);
        ill = m_illegal(addr, cmd);
        if (reset) begin
            m_ie = 0; m_prv = 3; m_ie1 = 0; m_prv1 = 3;
            m_scratch = 0; m_epc = 0; m_cause = 0; m_bad = 0;
            m_cycle = 0; m_instret = 0;
        end else begin
            m_cycle = m_cycle + 1;
            if (retire && !exception) m_instret = m_instret + 1;
            if (exception) begin
                m_epc   = exception_PC & 32'hFFFF_FFFC;
                m_cause = 32'(exception_code);
                if (exception_code == 4 || exception_code == 6) m_bad = exception_load_addr;
                m_prv1 = m_prv; m_ie1 = m_ie; m_prv = 3; m_ie = 0;
            end else begin
                if (m_is_write(cmd) && retire && !ill) begin
                    oldv = m_read(addr);
                    if (cmd == 3'd5)      newv = wdata;
                    else if (cmd == 3'd6) newv = oldv | wdata;
                    else                  newv = oldv & ~wdata;
                    case (addr)
                        12'h300: begin
                            m_ie = int'(newv[0]); m_prv = int'(newv[2:1]);
                            m_ie1 = int'(newv[3]); m_prv1 = int'(newv[5:4]);
                        end
                        12'h340: m_scratch = newv;
                        12'h341: m_epc = newv & 32'hFFFF_FFFC;
                        12'h342: m_cause = newv & 32'h8000_000F;
                        12'h343: m_bad = newv;
                        default: ;
                    endcase
                end
                if (eret) begin
                    m_prv = m_prv1; m_ie = m_ie1; m_prv1 = 0; m_ie1 = 1;
                end
            end
        end
        #1;
    endtask

    // Drive one cycle of stimulus, check it, then clock it in
    task automatic stepIo(input string tag, input logic [11:0] a, input logic [2:0] c,
                          input logic [31:0] wd, input logic ret);
        applyStimulus(1'b0, a, c, wd, ret, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput(tag);
    endtask

    logic [11:0] addr_pool [14];
    logic [2:0]  cmd_pool  [5];

    initial begin
        addr_pool = '{12'h300, 12'h340, 12'h341, 12'h342, 12'h343, 12'hC00, 12'hC80,
                      12'hC02, 12'hC82, 12'hF00, 12'hF01, 12'h305, 12'h123, 12'h7C0};
        cmd_pool  = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

        // Reset: the first edge brings the DUT out of X, the model follows
        applyStimulus(1'b1, 12'h0, 3'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("rst"); tick();
        check("rst_prv", {30'b0, prv}, 32'd3);
        check("rst_epc", epc, 32'd0);
        check("rst_handler", handler_PC, 32'h1C0);

        // 1: mstatus reset value and cycle counter
        stepIo("t1_mst", 12'h300, 3'd4, 32'd0, 1'b0);
        check("t1_mstatus", rdata, 32'h36);
        check("t1_idle_illegal", {31'b0, illegal_access}, 32'd0);
        tick();
        for (int i = 0; i < 9; i++) begin
            stepIo("t1_idle", 12'h000, 3'd0, 32'd0, 1'b0); tick();
        end
        stepIo("t1_cyc", 12'hC00, 3'd4, 32'd0, 1'b0);
        check("t1_cycle10", rdata, 32'd10);
        tick();

        // 2: read-modify-write of mscratch
        stepIo("t2_wr", 12'h340, 3'd5, 32'hDEADBEEF, 1'b1); tick();
        stepIo("t2_set", 12'h340, 3'd6, 32'h10, 1'b1);
        check("t2_after_write", rdata, 32'hDEADBEEF); tick();
        stepIo("t2_clr", 12'h340, 3'd7, 32'hF, 1'b1);
        check("t2_after_set", rdata, 32'hDEADBEFF); tick();
        stepIo("t2_rd", 12'h340, 3'd4, 32'd0, 1'b0);
        check("t2_after_clear", rdata, 32'hDEADBEF0); tick();

        // 3: trap with a concurrent mepc write that must be dropped
        applyStimulus(1'b0, 12'h341, 3'd5, 32'h55, 1'b1, 1'b1, 4'd4, 32'h204, 32'h1001, 1'b0);
        checkOutput("t3_exc"); tick();
        stepIo("t3_epc", 12'h341, 3'd4, 32'd0, 1'b0);
        check("t3_mepc", rdata, 32'h204);
        check("t3_epc_port", epc, 32'h204); tick();
        stepIo("t3_cause", 12'h342, 3'd4, 32'd0, 1'b0);
        check("t3_mcause", rdata, 32'h4); tick();
        stepIo("t3_bad", 12'h343, 3'd4, 32'd0, 1'b0);
        check("t3_mbadaddr", rdata, 32'h1001); tick();
        stepIo("t3_mst", 12'h300, 3'd4, 32'd0, 1'b0);
        check("t3_mstatus", rdata, 32'h36); tick();

        // 5: read-only writes are illegal; instret carry into the high word
        stepIo("t5_wc00", 12'hC00, 3'd5, 32'h1234, 1'b1);
        check("t5_c00_illegal", {31'b0, illegal_access}, 32'd1); tick();
        stepIo("t5_wf00", 12'hF00, 3'd6, 32'hFFFF, 1'b1);
        check("t5_f00_illegal", {31'b0, illegal_access}, 32'd1); tick();
        stepIo("t5_rf00", 12'hF00, 3'd4, 32'd0, 1'b0);
        check("t5_mcpuid", rdata, 32'h0); tick();
        force dut.instret_lo = 32'hFFFF_FFFF;
        stepIo("t5_f0", 12'h000, 3'd0, 32'd0, 1'b0); tick();
        stepIo("t5_f1", 12'h000, 3'd0, 32'd0, 1'b0); tick();
        release dut.instret_lo;
        m_instret = {m_instret[63:32], 32'hFFFF_FFFF};
        stepIo("t5_ret", 12'hC02, 3'd4, 32'd0, 1'b1);
        check("t5_pre_lo", rdata, 32'hFFFF_FFFF); tick();
        stepIo("t5_lo", 12'hC02, 3'd4, 32'd0, 1'b0);
        check("t5_instret_lo", rdata, 32'd0); tick();
        stepIo("t5_hi", 12'hC82, 3'd4, 32'd0, 1'b0);
        check("t5_instret_hi", rdata, 32'd1); tick();

        // 4: prepare the stack, eret to user mode, check privilege filtering
        stepIo("t4_wr", 12'h300, 3'd5, 32'h0E, 1'b1); tick();
        applyStimulus(1'b0, 12'h000, 3'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("t4_eret"); tick();
        check("t4_prv0", {30'b0, prv}, 32'd0);
        check("t4_handler0", handler_PC, 32'h100);
        stepIo("t4_r300", 12'h300, 3'd4, 32'd0, 1'b0);
        check("t4_mst_illegal", {31'b0, illegal_access}, 32'd1); tick();
        stepIo("t4_rc00", 12'hC00, 3'd4, 32'd0, 1'b0);
        check("t4_cycle_legal", {31'b0, illegal_access}, 32'd0); tick();
        applyStimulus(1'b0, 12'h000, 3'd0, 32'd0, 1'b1, 1'b1, 4'd2, 32'h403, 32'h0, 1'b1);
        checkOutput("t4_exc"); tick();
        check("t4_back_prv3", {30'b0, prv}, 32'd3);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0,
                          addr_pool[$urandom_range(13, 0)],
                          cmd_pool[$urandom_range(4, 0)],
                          ($urandom_range(3, 0) == 0) ? 32'($urandom_range(63, 0)) : $urandom,
                          $urandom_range(3, 0) != 0,
                          $urandom_range(15, 0) == 0,
                          4'($urandom_range(15, 0)),
                          $urandom,
                          $urandom,
                          $urandom_range(11, 0) == 0);
            checkOutput("rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
